// File: rtl/serial_shift_unit_pkg.sv
// ----------------------------------------------------------------------------
// serial_shift_unit_pkg
//   Shared encodings for the serial shift co-unit. The ALU decode stage uses
//   the same mode constants when it steers an operation to this unit.
//
//   Contents:
//     MODE_SRL / MODE_SLL / MODE_ROL / MODE_RSVD : 2-bit operation encodings
//     state_e                                    : FSM state encoding
//     is_passthrough()                           : true when no shift work is needed
// ----------------------------------------------------------------------------
package serial_shift_unit_pkg;

    // Operation encodings carried on in_mode.
    localparam logic [1:0] MODE_SRL  = 2'b00;  // logical right, zero fill
    localparam logic [1:0] MODE_SLL  = 2'b01;  // logical left, zero fill
    localparam logic [1:0] MODE_ROL  = 2'b10;  // rotate left
    localparam logic [1:0] MODE_RSVD = 2'b11;  // reserved, operand passes through

    // State encoding, fixed values so the ALU decode can observe it if needed.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // A request needs no shift steps when the amount is zero or the mode is
    // reserved; such requests go straight to DONE with the operand unchanged.
    function automatic logic is_passthrough(input logic [1:0] mode, input logic shamt_zero);
        return shamt_zero || (mode == MODE_RSVD);
    endfunction

endpackage

// File: rtl/serial_shift_unit_shift_step.sv
// ----------------------------------------------------------------------------
// shift_step
//   Purely combinational one-bit shift/rotate step, selected by mode.
//
//   Ports:
//     data    in   WIDTH  current working value
//     mode    in   2      operation (SRL/SLL/ROL/RSVD)
//     result  out  WIDTH  value after one step (unchanged for RSVD)
// ----------------------------------------------------------------------------
module shift_step
    import serial_shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        unique case (mode)
            MODE_SRL: result = {1'b0, data[WIDTH-1:1]};
            MODE_SLL: result = {data[WIDTH-2:0], 1'b0};
            MODE_ROL: result = {data[WIDTH-2:0], data[WIDTH-1]};
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/serial_shift_unit.sv
// ----------------------------------------------------------------------------
// serial_shift_unit
//   Multi-cycle shift/rotate engine, one bit per clock. Covers logical right,
//   logical left and rotate left. Operands arrive over a valid/ready handshake
//   and results leave over another.
//
//   Ports:
//     clk        in   1        rising-edge clock
//     rst_n      in   1        asynchronous active-low reset
//     in_valid   in   1        request valid
//     in_ready   out  1        unit idle and able to accept
//     in_data    in   WIDTH    operand
//     in_shamt   in   SHAMT_W  shift/rotate amount
//     in_mode    in   2        00 SRL, 01 SLL, 10 ROL, 11 pass-through
//     flush      in   1        synchronous abort, overrides everything
//     out_valid  out  1        result valid (DONE state)
//     out_ready  in   1        consumer takes the result
//     out_data   out  WIDTH    result
//     busy       out  1        unit not idle
// ----------------------------------------------------------------------------
module serial_shift_unit
    import serial_shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] count_q;
    logic [1:0]         mode_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   step_result;
    logic               accept;

    // One-bit step applied to the working register on every SHIFT edge.
    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .data   (data_q),
        .mode   (mode_q),
        .result (step_result)
    );

    // Ready depends on state only, never on in_valid.
    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            count_q     <= '0;
            mode_q      <= MODE_SRL;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            // Abort drops any in-flight result and blocks a same-cycle accept.
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        data_q  <= in_data;
                        mode_q  <= in_mode;
                        count_q <= in_shamt;
                        if (is_passthrough(in_mode, in_shamt == '0)) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end

                StShift: begin
                    data_q <= step_result;
                    // count is at least 1 here; the edge seeing 1 is the last step,
                    // so the counter never underflows.
                    if (count_q == SHAMT_W'(1)) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        count_q <= count_q - SHAMT_W'(1);
                    end
                end

                StDone: begin
                    // Result held stable until the consumer takes it.
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_shift_unit.sv
module tb_serial_shift_unit;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    in_shamt;
    logic [1:0]    in_mode;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    serial_shift_unit #(
        .WIDTH   (16),
        .SHAMT_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: whole-operation result from plain arithmetic.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int sh,
                                           input logic [1:0] m);
        logic [31:0] x;
        x = {16'b0, d};
        case (m)
            2'b00:   return W'(x >> sh);
            2'b01:   return W'(x << sh);
            2'b10:   return W'((x << sh) | (x >> (W - sh)));
            default: return d;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure latency, apply backpressure, and retire it.
    task automatic run_op(input logic [W-1:0] d, input int sh, input logic [1:0] m,
                          input int hold, input string tag);
        int eff;
        int lat;
        logic [W-1:0] exp;
        exp = model(d, sh, m);
        eff = (sh == 0 || m == 2'b11) ? 0 : sh;
        check({tag, " ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = 4'(sh);
        in_mode  = m;
        tick();
        // Scramble inputs after accept; in-flight result must not change.
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_shamt = 4'($urandom);
        in_mode  = 2'($urandom);
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " ready_low"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(eff));
        check({tag, " data"}, 32'(out_data), 32'(exp));
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_data"}, 32'(out_data), 32'(exp));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " retire_ready"}, 32'(in_ready), 32'd1);
        check({tag, " retire_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed cases.
        run_op(16'hFFFF, 8, 2'b00, 0, "srl_ffff_8");
        run_op(16'h0001, 15, 2'b01, 0, "sll_0001_15");
        run_op(16'h8001, 1, 2'b10, 0, "rol_8001_1");
        run_op(16'h1234, 4, 2'b10, 0, "rol_1234_4");
        run_op(16'h1234, 0, 2'b00, 0, "shamt0_srl");
        run_op(16'h1234, 0, 2'b10, 0, "shamt0_rol");
        run_op(16'h1234, 7, 2'b11, 0, "rsvd_7");
        run_op(16'hA5C3, 5, 2'b01, 3, "backpressure");

        // Flush mid-shift: accept is edge 1, flush sampled at edge 4.
        in_valid = 1'b1;
        in_data  = 16'h00FF;
        in_shamt = 4'd10;
        in_mode  = 2'b01;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        check("flush idle", 32'(in_ready), 32'd1);
        check("flush busy", 32'(busy), 32'd0);
        check("flush no_valid", 32'(out_valid), 32'd0);
        // Request alongside flush must be refused.
        in_valid = 1'b1;
        in_data  = 16'h1111;
        in_shamt = 4'd0;
        in_mode  = 2'b00;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush refuse busy", 32'(busy), 32'd0);
        check("flush refuse valid", 32'(out_valid), 32'd0);
        tick();
        check("flush still idle", 32'(busy), 32'd0);
        run_op(16'h8000, 15, 2'b00, 0, "after_flush");

        // Asynchronous reset mid-shift.
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        in_shamt = 4'd12;
        in_mode  = 2'b10;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async in_ready", 32'(in_ready), 32'd1);
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async out_data", 32'(out_data), 32'h0);
        check("async busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized back-to-back traffic.
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), int'($urandom_range(0, 15)), 2'($urandom),
                   int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
